// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - shared ALU op codes, FSM states and destination selects
package instr_pack;

  typedef enum logic [4:0] {
    AMP   = 5'd0,
    LOR   = 5'd1,
    FLP   = 5'd2,
    EOR   = 5'd3,
    RSC   = 5'd4,
    LSC   = 5'd5,
    ROL   = 5'd6,
    ROR   = 5'd7,
    ADD   = 5'd8,
    SUB   = 5'd9,
    EQL   = 5'd10,
    EQLLO = 5'd11,
    REVX  = 5'd12,
    REVY  = 5'd13,
    PARX  = 5'd14,
    PARY  = 5'd15,
    MUL   = 5'd16,
    DIV   = 5'd17
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } alu_st_e;

  localparam logic DST_R = 1'b0;
  localparam logic DST_S = 1'b1;

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - W-step shift-add multiply / restoring divide datapath
module seq_alu_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  hi, lo, opb;
  logic          div_m;
  logic [CW-1:0] cnt;
  logic [W:0]    t, add_a, add_b, sum;
  logic          ge;

  // One W+1-bit adder: hi+multiplicand for MUL, shifted remainder minus divisor for DIV.
  always_comb begin
    t = {hi, lo[W-1]};
    if (div_m) begin
      add_a = t;
      add_b = ~{1'b0, opb};
    end else begin
      add_a = {1'b0, hi};
      add_b = lo[0] ? {1'b0, opb} : '0;
    end
    sum = add_a + add_b + {{W{1'b0}}, div_m};
    // A set top bit of t means it already exceeds any W-bit divisor.
    ge = t[W] | ~sum[W];
    if (div_m) begin
      res_hi = ge ? sum[W-1:0] : t[W-1:0];
      res_lo = {lo[W-2:0], ge};
    end else begin
      res_hi = sum[W:1];
      res_lo = {sum[0], lo[W-1:1]};
    end
  end

  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      div_m <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      opb   <= b;
      div_m <= is_div;
      cnt   <= '0;
    end else if (step) begin
      hi    <= res_hi;
      lo    <= res_lo;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with r/s result registers, flags and multi-cycle MUL/DIV
module seq_alu
  import instr_pack::*;
#(
  parameter int W      = 8,
  parameter int CMP_LO = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  alu_op_e      op,
  input  logic         dst,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r_out,
  output logic [W-1:0] s_out,
  output logic         carry,
  output logic         zero
);

  localparam int SW = $clog2(W);
  localparam logic [W-1:0] LO_MASK = {W{1'b1}} >> (W - CMP_LO);

  alu_st_e      state;
  logic         iter_div;
  logic [W-1:0] res;
  logic         res_c;
  logic [2*W-1:0] rot;
  logic [W:0]   ext;
  logic         div0, load, last;
  logic [W-1:0] it_lo, it_hi;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    rot   = '0;
    ext   = '0;
    case (op)
      AMP:   res = x & y;
      LOR:   res = x | y;
      FLP:   res = ~x;
      EOR:   res = x ^ y;
      RSC:   begin res = {y[0], x[W-1:1]}; res_c = x[0]; end
      LSC:   begin res = {x[W-2:0], y[W-1]}; res_c = x[W-1]; end
      ROL:   begin rot = {x, x} << y[SW-1:0]; res = rot[2*W-1:W]; end
      ROR:   begin rot = {x, x} >> y[SW-1:0]; res = rot[W-1:0]; end
      ADD:   begin ext = {1'b0, x} + {1'b0, y}; res = ext[W-1:0]; res_c = ext[W]; end
      SUB:   begin ext = {1'b0, x} - {1'b0, y}; res = ext[W-1:0]; res_c = ~ext[W]; end
      EQL:   res = {{(W-1){1'b0}}, x == y};
      EQLLO: res = {{(W-1){1'b0}}, ((x ^ y) & LO_MASK) == '0};
      REVX:  for (int i = 0; i < W; i++) res[i] = x[W-1-i];
      REVY:  for (int i = 0; i < W; i++) res[i] = y[W-1-i];
      PARX:  res = {{(W-1){1'b0}}, ^x};
      PARY:  res = {{(W-1){1'b0}}, ^y};
      default: ;
    endcase
  end

  assign div0 = (op == DIV) && (y == '0);
  assign load = (state == IDLE) && start && ((op == MUL) || (op == DIV)) && !div0;

  seq_alu_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (state == ITER),
    .is_div (op == DIV),
    .a      (x),
    .b      (y),
    .last   (last),
    .res_lo (it_lo),
    .res_hi (it_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_div <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_out    <= '0;
      s_out    <= {{(W-1){1'b0}}, 1'b1};
      carry    <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= ITER;
            iter_div <= (op == DIV);
            busy     <= 1'b1;
          end else if (start) begin
            done <= 1'b1;
            if (div0) begin
              r_out <= '1;
              s_out <= x;
              carry <= 1'b1;
              zero  <= 1'b0;
            end else begin
              if (dst == DST_S) s_out <= res;
              else              r_out <= res;
              carry <= res_c;
              zero  <= (res == '0);
            end
          end
        end
        ITER: begin
          // The last iteration's combinational result is written directly.
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            r_out <= it_lo;
            s_out <= it_hi;
            carry <= !iter_div && (it_hi != '0);
            zero  <= (it_lo == '0) && (it_hi == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed-vector bench for seq_alu with an arithmetic reference model
module tb_seq_alu;
  import instr_pack::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  alu_op_e    op = AMP;
  logic       dst = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic       busy, done, carry, zero;
  logic [W-1:0] r_out, s_out;

  seq_alu #(.W(W), .CMP_LO(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dst(dst), .x(x), .y(y),
    .busy(busy), .done(done), .r_out(r_out), .s_out(s_out), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  logic [7:0] exp_r = 8'h00, exp_s = 8'h01;
  logic       exp_c = 1'b0, exp_z = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("r_out", 32'(r_out), 32'(exp_r));
      chk("s_out", 32'(s_out), 32'(exp_s));
      chk("carry", 32'(carry), 32'(exp_c));
      chk("zero",  32'(zero),  32'(exp_z));
      chk("busy",  32'(busy),  32'(exp_busy));
      chk("done",  32'(done),  32'(exp_done));
    end
  end

  // Reference model: plain integer arithmetic on W=8 operands.
  task automatic model(input int o, input int a, input int b, input logic d);
    int res, c, n, p;
    res = 0; c = 0;
    n = b % 8;
    if (o == 16) begin
      p = a * b;
      exp_r = 8'(p % 256); exp_s = 8'(p / 256);
      exp_c = (p / 256) != 0; exp_z = (p == 0);
      return;
    end
    if (o == 17) begin
      if (b == 0) begin
        exp_r = 8'hFF; exp_s = 8'(a); exp_c = 1'b1; exp_z = 1'b0;
      end else begin
        exp_r = 8'(a / b); exp_s = 8'(a % b); exp_c = 1'b0;
        exp_z = (a / b == 0) && (a % b == 0);
      end
      return;
    end
    case (o)
      0:  res = a & b;
      1:  res = a | b;
      2:  res = 255 - a;
      3:  res = a ^ b;
      4:  begin res = ((b % 2) * 128) + a / 2; c = a % 2; end
      5:  begin res = (a * 2) % 256 + b / 128; c = a / 128; end
      6:  res = ((a << n) | (a >> (8 - n))) & 255;
      7:  res = ((a >> n) | (a << (8 - n))) & 255;
      8:  begin res = (a + b) % 256; c = (a + b) > 255; end
      9:  begin res = (a - b + 256) % 256; c = (a >= b); end
      10: res = (a == b);
      11: res = ((a % 32) == (b % 32));
      12: for (int i = 0; i < 8; i++) res |= ((a >> i) & 1) << (7 - i);
      13: for (int i = 0; i < 8; i++) res |= ((b >> i) & 1) << (7 - i);
      14: res = $countones(a) % 2;
      15: res = $countones(b) % 2;
      default: res = 0;
    endcase
    if (d) exp_s = 8'(res); else exp_r = 8'(res);
    exp_c = c[0];
    exp_z = (res == 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the op has completed.
  task automatic issue(input alu_op_e o, input logic [7:0] a, input logic [7:0] b,
                       input logic d, input int inject);
    op = o; x = a; y = b; dst = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if ((o == MUL) || (o == DIV && b != 0)) begin
      exp_busy = 1'b1; exp_done = 1'b0;
      op = ADD; x = 8'h00; y = 8'h00;
      for (int k = 1; k <= W; k++) begin
        if (k == inject) begin
          start = 1'b1; x = 8'h11; y = 8'h22; dst = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (k == W) begin
          model(int'(o), int'(a), int'(b), d);
          exp_busy = 1'b0; exp_done = 1'b1;
        end
      end
    end else begin
      model(int'(o), int'(a), int'(b), d);
      exp_done = 1'b1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    exp_done = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset r_out", 32'(r_out), 32'h00);
    chk("reset s_out", 32'(s_out), 32'h01);
    rst_n = 1'b1;
    idle();

    issue(ADD, 8'hF0, 8'h20, 1'b0, 0);
    chk("add r_out", 32'(r_out), 32'h10);
    chk("add carry", 32'(carry), 32'h1);
    issue(SUB, 8'h05, 8'h05, 1'b1, 0);
    chk("sub s_out", 32'(s_out), 32'h00);
    chk("sub zero", 32'(zero), 32'h1);
    chk("sub keeps r", 32'(r_out), 32'h10);
    idle();

    issue(MUL, 8'hFF, 8'hFF, 1'b0, 0);
    chk("mul lo", 32'(r_out), 32'h01);
    chk("mul hi", 32'(s_out), 32'hFE);
    issue(DIV, 8'd200, 8'd7, 1'b0, 0);
    chk("div quo", 32'(r_out), 32'd28);
    chk("div rem", 32'(s_out), 32'd4);
    issue(DIV, 8'h5A, 8'h00, 1'b0, 0);
    chk("div0 r", 32'(r_out), 32'hFF);
    chk("div0 s", 32'(s_out), 32'h5A);

    issue(ROL, 8'h81, 8'h0B, 1'b0, 0);
    chk("rol r", 32'(r_out), 32'h0C);
    issue(RSC, 8'h03, 8'h01, 1'b0, 0);
    chk("rsc r", 32'(r_out), 32'h81);
    issue(EQLLO, 8'h25, 8'hE5, 1'b0, 0);
    chk("eqllo r", 32'(r_out), 32'h01);

    issue(AMP, 8'hCC, 8'hAA, 1'b1, 0);
    issue(LOR, 8'hC0, 8'h0A, 1'b0, 0);
    issue(FLP, 8'h3C, 8'h00, 1'b1, 0);
    issue(EOR, 8'hFF, 8'hFF, 1'b0, 0);
    issue(LSC, 8'h81, 8'h80, 1'b1, 0);
    issue(ROR, 8'h81, 8'h01, 1'b0, 0);
    issue(ROL, 8'h5A, 8'h08, 1'b1, 0);
    issue(EQL, 8'h25, 8'hE5, 1'b0, 0);
    issue(EQL, 8'h77, 8'h77, 1'b1, 0);
    issue(REVX, 8'h01, 8'h00, 1'b0, 0);
    issue(REVY, 8'h00, 8'hC2, 1'b1, 0);
    issue(PARX, 8'h07, 8'h00, 1'b0, 0);
    issue(PARY, 8'h00, 8'h03, 1'b1, 0);
    issue(SUB, 8'h03, 8'h05, 1'b0, 0);
    issue(alu_op_e'(5'd25), 8'h12, 8'h34, 1'b1, 0);
    idle();
    issue(MUL, 8'h00, 8'h9C, 1'b0, 0);
    issue(DIV, 8'hFF, 8'h10, 1'b0, 0);
    idle();

    issue(MUL, 8'h0D, 8'h0B, 1'b0, 3);
    chk("mul after ignored start", 32'(r_out), 32'd143);
    idle();

    op = MUL; x = 8'h12; y = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_r = 8'h00; exp_s = 8'h01; exp_c = 1'b0; exp_z = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort s_out", 32'(s_out), 32'h01);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (W + 2) idle();
    issue(ADD, 8'h01, 8'h02, 1'b0, 0);
    chk("add after abort", 32'(r_out), 32'h03);
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
